// File: rtl/seg7_msg_scroller_pkg.sv
// Shared constants for the message scroller: segment patterns, character codes, mode enum.
// Segment patterns are active-low {dp,g,f,e,d,c,b,a}, so a cleared bit lights that segment.
package seg7_msg_scroller_pkg;

  typedef enum logic {
    MODE_STATIC = 1'b0,
    MODE_SCROLL = 1'b1
  } mode_e;

  localparam logic [7:0] SS_N     = 8'hAB;  // c,e,g
  localparam logic [7:0] SS_T     = 8'h87;  // d,e,f,g
  localparam logic [7:0] SS_H     = 8'h89;  // b,c,e,f,g
  localparam logic [7:0] SS_U     = 8'hC1;  // b,c,d,e,f
  localparam logic [7:0] SS_E     = 8'h86;  // a,d,e,f,g
  localparam logic [7:0] SS_C     = 8'hC6;  // a,d,e,f
  localparam logic [7:0] SS_S     = 8'h92;  // a,c,d,f,g
  localparam logic [7:0] SS_0     = 8'hC0;  // a..f
  localparam logic [7:0] SS_BLANK = 8'hFF;  // all segments off

  // Character codes shared with the user input logic.
  localparam int CH_N = 0;
  localparam int CH_T = 1;
  localparam int CH_H = 2;
  localparam int CH_U = 3;
  localparam int CH_E = 4;
  localparam int CH_C = 5;
  localparam int CH_S = 6;
  localparam int CH_0 = 7;

endpackage

// File: rtl/seg7_msg_scroller_if.sv
// Bus between the user input logic (master) and the scroller (slave).
interface seg7_msg_scroller_if #(
  parameter int N_DIGITS = 4,
  parameter int MSG_LEN  = 8,
  parameter int CHAR_W   = 3
);
  logic [CHAR_W-1:0]              char_in;
  logic                           char_we;
  logic                           clear;
  logic                           mode;
  logic [7:0]                     seg;
  logic [N_DIGITS-1:0]            an;
  logic [$clog2(MSG_LEN+1)-1:0]   count;
  logic                           full;
  logic                           overflow;

  modport master (
    output char_in, char_we, clear, mode,
    input  seg, an, count, full, overflow
  );

  modport slave (
    input  char_in, char_we, clear, mode,
    output seg, an, count, full, overflow
  );
endinterface

// File: rtl/seg7_msg_scroller_char_lut.sv
// Character code to seven-segment pattern table; empty slots and unknown codes are blank.
module seg7_char_lut
  import seg7_msg_scroller_pkg::*;
#(
  parameter int CHAR_W = 3
) (
  input  logic [CHAR_W-1:0] code,
  input  logic              vld,
  output logic [7:0]        seg
);

  // Table lookup, gated by slot occupancy.
  always_comb begin
    seg = SS_BLANK;
    if (vld) begin
      case (32'(code))
        CH_N:    seg = SS_N;
        CH_T:    seg = SS_T;
        CH_H:    seg = SS_H;
        CH_U:    seg = SS_U;
        CH_E:    seg = SS_E;
        CH_C:    seg = SS_C;
        CH_S:    seg = SS_S;
        CH_0:    seg = SS_0;
        default: seg = SS_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/seg7_msg_scroller.sv
// Message buffer + digit scan + optional scroll for a multiplexed seven-segment display.
// seg/an are registered together from the scan index so they always change in the same cycle.
module seg7_msg_scroller
  import seg7_msg_scroller_pkg::*;
#(
  parameter int N_DIGITS   = 4,
  parameter int MSG_LEN    = 8,
  parameter int CHAR_W     = 3,
  parameter int SCAN_DIV   = 100000,
  parameter int SCROLL_DIV = 25000000
) (
  input logic                clk,
  input logic                rst_n,
  seg7_msg_scroller_if.slave bus
);

  localparam int CNT_W  = $clog2(MSG_LEN + 1);
  localparam int OFF_W  = $clog2(MSG_LEN + N_DIGITS);
  localparam int POS_W  = $clog2(MSG_LEN + 2 * N_DIGITS);
  localparam int IDX_W  = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int SCRL_W = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;

  logic [CHAR_W-1:0]   buf_q [MSG_LEN];
  logic [CHAR_W-1:0]   buf_d [MSG_LEN];
  logic [CNT_W-1:0]    count_q, count_d;
  logic                overflow_q, overflow_d;
  logic [OFF_W-1:0]    offset_q, offset_d;
  logic [SCRL_W-1:0]   scrl_tmr_q, scrl_tmr_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [SCAN_W-1:0]   scan_tmr_q, scan_tmr_d;
  mode_e               mode_q, mode_d;
  logic [7:0]          seg_q, seg_d;
  logic [N_DIGITS-1:0] an_q, an_d;

  logic                full;
  logic [POS_W-1:0]    pos;
  logic [POS_W-1:0]    nxt_off;
  logic [POS_W-1:0]    wrap_pt;
  logic [CHAR_W-1:0]   ch;
  logic                ch_vld;
  logic [7:0]          lut_seg;

  assign full = (count_q == CNT_W'(MSG_LEN));

  // Buffer append / clear; clear wins over a same-cycle write and suppresses overflow.
  always_comb begin
    buf_d      = buf_q;
    count_d    = count_q;
    overflow_d = 1'b0;
    if (bus.clear) begin
      count_d = '0;
    end else if (bus.char_we) begin
      if (full) begin
        overflow_d = 1'b1;
      end else begin
        for (int i = 0; i < MSG_LEN; i++)
          if (count_q == CNT_W'(i)) buf_d[i] = bus.char_in;
        count_d = count_q + 1'b1;
      end
    end
  end

  // Digit scan timer and index.
  always_comb begin
    scan_tmr_d = scan_tmr_q + 1'b1;
    idx_d      = idx_q;
    if (scan_tmr_q == SCAN_W'(SCAN_DIV - 1)) begin
      scan_tmr_d = '0;
      idx_d      = (idx_q == IDX_W'(N_DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end
  end

  // Scroll offset: parked at 0 in STATIC, on empty buffer, on clear and on any mode change.
  // The wrap point is count+N_DIGITS so the message is followed by a full blank gap.
  always_comb begin
    mode_d     = mode_e'(bus.mode);
    offset_d   = offset_q;
    scrl_tmr_d = scrl_tmr_q;
    nxt_off    = POS_W'(offset_q) + 1'b1;
    wrap_pt    = POS_W'(count_q) + POS_W'(N_DIGITS);
    if (bus.clear || (mode_d != mode_q) || (mode_d == MODE_STATIC) || (count_q == '0)) begin
      offset_d   = '0;
      scrl_tmr_d = '0;
    end else begin
      scrl_tmr_d = scrl_tmr_q + 1'b1;
      if (scrl_tmr_q == SCRL_W'(SCROLL_DIV - 1)) begin
        scrl_tmr_d = '0;
        offset_d   = (nxt_off >= wrap_pt) ? '0 : OFF_W'(nxt_off);
      end
    end
  end

  // Character for the digit currently being scanned; positions past the tail are blank.
  always_comb begin
    pos    = POS_W'(idx_q) + POS_W'(offset_q);
    ch_vld = (pos < POS_W'(count_q));
    ch     = '0;
    for (int i = 0; i < MSG_LEN; i++)
      if (pos == POS_W'(i)) ch = buf_q[i];
  end

  seg7_char_lut #(.CHAR_W(CHAR_W)) u_lut (
    .code (ch),
    .vld  (ch_vld),
    .seg  (lut_seg)
  );

  // Output pattern and matching digit enable, both from the same idx.
  always_comb begin
    seg_d = lut_seg;
    an_d  = ~(N_DIGITS'(1) << idx_q);
  end

  // Control state with async reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q    <= '0;
      overflow_q <= 1'b0;
      offset_q   <= '0;
      scrl_tmr_q <= '0;
      idx_q      <= '0;
      scan_tmr_q <= '0;
      mode_q     <= MODE_STATIC;
      seg_q      <= SS_BLANK;
      an_q       <= '1;
    end else begin
      count_q    <= count_d;
      overflow_q <= overflow_d;
      offset_q   <= offset_d;
      scrl_tmr_q <= scrl_tmr_d;
      idx_q      <= idx_d;
      scan_tmr_q <= scan_tmr_d;
      mode_q     <= mode_d;
      seg_q      <= seg_d;
      an_q       <= an_d;
    end
  end

  // Buffer storage; contents are masked by count, so no reset needed.
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

  assign bus.seg      = seg_q;
  assign bus.an       = an_q;
  assign bus.count    = count_q;
  assign bus.full     = full;
  assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_seg7_msg_scroller.sv
// Directed bench for seg7_msg_scroller with fast scan/scroll dividers.
module tb_seg7_msg_scroller;
  import seg7_msg_scroller_pkg::*;

  localparam int ND = 4;
  localparam int ML = 8;
  localparam int CW = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;
  logic [7:0] dig [ND];
  logic [7:0] d0;

  always #5 clk = ~clk;

  seg7_msg_scroller_if #(.N_DIGITS(ND), .MSG_LEN(ML), .CHAR_W(CW)) bus ();

  seg7_msg_scroller #(
    .N_DIGITS(ND), .MSG_LEN(ML), .CHAR_W(CW), .SCAN_DIV(4), .SCROLL_DIV(64)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [CW-1:0] c);
    bus.char_in = c;
    bus.char_we = 1'b1;
    tick();
    bus.char_we = 1'b0;
  endtask

  task automatic do_clear();
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
  endtask

  // Watch two full scan rounds and record what each digit shows.
  task automatic scan_digits();
    for (int d = 0; d < ND; d++) dig[d] = 8'h00;
    repeat (2 * ND * 4 + 2) begin
      tick();
      for (int d = 0; d < ND; d++)
        if (bus.an == ~(ND'(1) << d)) dig[d] = bus.seg;
    end
  endtask

  logic [7:0] exp_scr [7];
  logic [3:0] exp_an;

  initial begin
    bus.char_in = '0;
    bus.char_we = 1'b0;
    bus.clear   = 1'b0;
    bus.mode    = 1'b0;
    exp_scr = '{SS_N, SS_U, SS_BLANK, SS_BLANK, SS_BLANK, SS_BLANK, SS_N};

    // 1: reset values, then idle scan with blank segments
    #12;
    chk("rst_an", 32'(bus.an), 32'hF);
    chk("rst_seg", 32'(bus.seg), 32'(SS_BLANK));
    chk("rst_count", 32'(bus.count), 0);
    chk("rst_full", 32'(bus.full), 0);
    chk("rst_ovf", 32'(bus.overflow), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    for (int s = 0; s < 5; s++) begin
      exp_an = ~(4'b0001 << (s % 4));
      chk($sformatf("scan_an%0d", s), 32'(bus.an), 32'(exp_an));
      chk($sformatf("scan_seg%0d", s), 32'(bus.seg), 32'(SS_BLANK));
      repeat (4) tick();
    end

    // 2: STATIC T,H,E
    wr(3'd1); wr(3'd2); wr(3'd4);
    chk("the_count", 32'(bus.count), 3);
    scan_digits();
    chk("the_d0", 32'(dig[0]), 32'(SS_T));
    chk("the_d1", 32'(dig[1]), 32'(SS_H));
    chk("the_d2", 32'(dig[2]), 32'(SS_E));
    chk("the_d3", 32'(dig[3]), 32'(SS_BLANK));

    // 3: fill and overflow
    do_clear();
    chk("clr_count", 32'(bus.count), 0);
    for (int i = 0; i < 7; i++) wr(CW'(i));
    chk("full_at7", 32'(bus.full), 0);
    wr(3'd7);
    chk("full_at8", 32'(bus.full), 1);
    chk("ovf_at8", 32'(bus.overflow), 0);
    wr(3'd0);
    chk("ovf_at9", 32'(bus.overflow), 1);
    chk("count_at9", 32'(bus.count), 8);
    tick();
    chk("ovf_pulse_end", 32'(bus.overflow), 0);
    scan_digits();
    chk("full_d0", 32'(dig[0]), 32'(SS_N));
    chk("full_d3", 32'(dig[3]), 32'(SS_U));

    // 5: clear beats write with count=5
    do_clear();
    wr(3'd6); wr(3'd5); wr(3'd4); wr(3'd3); wr(3'd2);
    chk("five_count", 32'(bus.count), 5);
    bus.clear = 1'b1; bus.char_we = 1'b1; bus.char_in = 3'd1;
    tick();
    bus.clear = 1'b0; bus.char_we = 1'b0;
    chk("clrwe_count", 32'(bus.count), 0);
    chk("clrwe_ovf", 32'(bus.overflow), 0);
    scan_digits();
    for (int d = 0; d < ND; d++)
      chk($sformatf("clrwe_d%0d", d), 32'(dig[d]), 32'(SS_BLANK));

    // 4: SCROLL "NU", digit0 over 7 steps
    wr(3'd0); wr(3'd3);
    bus.mode = 1'b1;
    tick();
    for (int k = 0; k < 7; k++) begin
      repeat (20) tick();
      d0 = 8'h00;
      repeat (16) begin
        tick();
        if (bus.an == 4'b1110) d0 = bus.seg;
      end
      chk($sformatf("scroll_step%0d", k), 32'(d0), 32'(exp_scr[k]));
      repeat (28) tick();
    end

    // 6: mode toggle at offset 3, then async reset mid-scan
    repeat (128) tick();
    chk("off_before_toggle", 32'(dut.offset_q), 3);
    bus.mode = 1'b0;
    tick();
    chk("off_after_toggle", 32'(dut.offset_q), 0);
    repeat (2) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("async_an", 32'(bus.an), 32'hF);
    chk("async_seg", 32'(bus.seg), 32'(SS_BLANK));
    chk("async_count", 32'(bus.count), 0);
    chk("async_full", 32'(bus.full), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post_rst_an", 32'(bus.an), 32'hE);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
